// File: rtl/pipelined_adder.sv
// WIDTH-bit add/subtract whose carry chain is cut into STAGES slices, one slice
// resolved per clock, with valid/ready handshakes and full backpressure.
module pipelined_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int SW = WIDTH / STAGES;
  localparam int L  = STAGES - 1;

  generate
    if ((WIDTH % STAGES) != 0 || WIDTH < 2) begin : g_bad_params
      $error("pipelined_adder: WIDTH must be >= 2 and a multiple of STAGES");
    end
  endgenerate

  logic             advance;
  logic             v_q   [STAGES];
  logic             v_d   [STAGES];
  logic [WIDTH-1:0] a_q   [STAGES];
  logic [WIDTH-1:0] a_d   [STAGES];
  logic [WIDTH-1:0] b_q   [STAGES];
  logic [WIDTH-1:0] b_d   [STAGES];
  logic [WIDTH-1:0] s_q   [STAGES];
  logic [WIDTH-1:0] s_d   [STAGES];
  logic             c_q   [STAGES];
  logic             c_d   [STAGES];
  logic             ovf_q;
  logic             ovf_d;

  logic [WIDTH-1:0] a_in  [STAGES];
  logic [WIDTH-1:0] b_in  [STAGES];
  logic [WIDTH-1:0] s_in  [STAGES];
  logic             c_in  [STAGES];
  logic [SW:0]      slice;

  always_comb begin
    advance = !v_q[L] || out_ready;

    // Stage 0 sees the conditioned operands; later stages see the previous stage registers.
    a_in[0] = in_a;
    b_in[0] = in_b ^ {WIDTH{in_sub}};
    s_in[0] = '0;
    c_in[0] = in_cin ^ in_sub;
    for (int k = 1; k < STAGES; k++) begin
      a_in[k] = a_q[k-1];
      b_in[k] = b_q[k-1];
      s_in[k] = s_q[k-1];
      c_in[k] = c_q[k-1];
    end

    slice = '0;
    for (int k = 0; k < STAGES; k++) begin
      slice = {1'b0, a_in[k][k*SW +: SW]} + {1'b0, b_in[k][k*SW +: SW]}
            + {{SW{1'b0}}, c_in[k]};
      a_d[k] = a_in[k];
      b_d[k] = b_in[k];
      s_d[k] = s_in[k];
      s_d[k][k*SW +: SW] = slice[SW-1:0];
      c_d[k] = slice[SW];
    end

    v_d[0] = in_valid && advance;
    for (int k = 1; k < STAGES; k++) begin
      v_d[k] = v_q[k-1];
    end

    // Carry into the MSB is recovered as a ^ b ^ sum at that bit.
    ovf_d = a_in[L][WIDTH-1] ^ b_in[L][WIDTH-1] ^ s_d[L][WIDTH-1] ^ c_d[L];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        v_q[k] <= 1'b0;
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
        c_q[k] <= 1'b0;
      end
      ovf_q <= 1'b0;
    end else if (advance) begin
      for (int k = 0; k < STAGES; k++) begin
        v_q[k] <= v_d[k];
        a_q[k] <= a_d[k];
        b_q[k] <= b_d[k];
        s_q[k] <= s_d[k];
        c_q[k] <= c_d[k];
      end
      ovf_q <= ovf_d;
    end
  end

  assign in_ready  = advance;
  assign out_valid = v_q[L];
  assign out_sum   = s_q[L];
  assign out_cout  = c_q[L];
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench for pipelined_adder: three instances (STAGES = 4, 1, 16)
// share one stimulus stream; each has its own expected-result queue.
module tb_pipelined_adder;

  localparam int W = 16;

  logic          clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          in_valid;
  logic          in_cin;
  logic          in_sub;
  logic          out_ready;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;

  logic          in_ready_w  [3];
  logic          out_valid_w [3];
  logic          out_cout_w  [3];
  logic          out_ovf_w   [3];
  logic [W-1:0]  out_sum_w   [3];

  pipelined_adder #(.WIDTH(W), .STAGES(4)) u_s4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w[0]),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
    .out_valid(out_valid_w[0]), .out_ready(out_ready), .out_sum(out_sum_w[0]),
    .out_cout(out_cout_w[0]), .out_ovf(out_ovf_w[0]));

  pipelined_adder #(.WIDTH(W), .STAGES(1)) u_s1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w[1]),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
    .out_valid(out_valid_w[1]), .out_ready(out_ready), .out_sum(out_sum_w[1]),
    .out_cout(out_cout_w[1]), .out_ovf(out_ovf_w[1]));

  pipelined_adder #(.WIDTH(W), .STAGES(16)) u_s16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w[2]),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
    .out_valid(out_valid_w[2]), .out_ready(out_ready), .out_sum(out_sum_w[2]),
    .out_cout(out_cout_w[2]), .out_ovf(out_ovf_w[2]));

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: {ovf, cout, sum} from a full-width add and the sign rule for overflow.
  function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic cin, input logic sub);
    logic [15:0] bb;
    logic [16:0] full;
    logic        ovf;
    bb   = sub ? ~b : b;
    full = {1'b0, a} + {1'b0, bb} + 17'(cin ^ sub);
    ovf  = (a[15] == bb[15]) && (full[15] != a[15]);
    return {ovf, full[16], full[15:0]};
  endfunction

  logic [17:0] sb0 [$];
  logic [17:0] sb1 [$];
  logic [17:0] sb2 [$];
  logic [17:0] mon_m;
  logic [17:0] mon_got;
  logic [17:0] mon_exp;
  logic        mon_have;

  always @(negedge clk) begin
    if (rst) begin
      sb0.delete();
      sb1.delete();
      sb2.delete();
    end else begin
      mon_m = model(in_a, in_b, in_cin, in_sub);
      for (int i = 0; i < 3; i++) begin
        if (out_valid_w[i] && out_ready) begin
          mon_got  = {out_ovf_w[i], out_cout_w[i], out_sum_w[i]};
          mon_have = 1'b0;
          mon_exp  = '0;
          case (i)
            0: if (sb0.size() > 0) begin mon_exp = sb0.pop_front(); mon_have = 1'b1; end
            1: if (sb1.size() > 0) begin mon_exp = sb1.pop_front(); mon_have = 1'b1; end
            default: if (sb2.size() > 0) begin mon_exp = sb2.pop_front(); mon_have = 1'b1; end
          endcase
          if (mon_have)
            check_eq($sformatf("sb_out_dut%0d", i), 32'(mon_got), 32'(mon_exp));
          else
            check_eq($sformatf("spurious_out_dut%0d", i), 32'(out_valid_w[i]), 32'd0);
        end
        if (in_valid && in_ready_w[i]) begin
          case (i)
            0: sb0.push_back(mon_m);
            1: sb1.push_back(mon_m);
            default: sb2.push_back(mon_m);
          endcase
        end
      end
    end
  end

  task automatic directed(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic cin, input logic sub, input logic [15:0] e_sum,
                          input logic e_cout, input logic e_ovf);
    int          lat [3];
    logic [17:0] got;
    bit          done;
    lat = '{0, 0, 0};
    got = '0;
    @(posedge clk); #1;
    in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_valid = 1'b1;
    #3 check_eq({tag, "_in_ready"}, 32'(in_ready_w[0]), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      for (int i = 0; i < 3; i++) begin
        if (out_valid_w[i] && lat[i] == 0) begin
          lat[i] = n;
          if (i == 0) got = {out_ovf_w[0], out_cout_w[0], out_sum_w[0]};
        end
      end
      done = (lat[0] != 0) && (lat[1] != 0) && (lat[2] != 0);
      if (done) break;
      @(posedge clk); #1;
    end
    check_eq({tag, "_lat_s4"}, 32'(lat[0]), 32'd4);
    check_eq({tag, "_lat_s1"}, 32'(lat[1]), 32'd1);
    check_eq({tag, "_lat_s16"}, 32'(lat[2]), 32'd16);
    check_eq({tag, "_result"}, 32'(got), 32'({e_ovf, e_cout, e_sum}));
  endtask

  task automatic drive_random();
    in_a     = 16'($urandom);
    in_b     = 16'($urandom);
    in_cin   = 1'($urandom);
    in_sub   = 1'($urandom);
    in_valid = 1'b1;
  endtask

  task automatic check_reset_state(input string tag);
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("%s_out_valid%0d", tag, i), 32'(out_valid_w[i]), 32'd0);
      check_eq($sformatf("%s_out_sum%0d", tag, i), 32'(out_sum_w[i]), 32'd0);
      check_eq($sformatf("%s_flags%0d", tag, i), 32'({out_cout_w[i], out_ovf_w[i]}), 32'd0);
      check_eq($sformatf("%s_in_ready%0d", tag, i), 32'(in_ready_w[i]), 32'd1);
    end
  endtask

  initial begin
    int          first;
    int          cnt;
    int          last;
    int          sent;
    logic [17:0] hold_val;
    bit          acc;
    bit          stall;

    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0;
    in_cin = 1'b0; in_sub = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1 check_reset_state("reset");

    directed("carry_all", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    directed("ovf_add",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    directed("ovf_sub",   16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    directed("borrow",    16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    directed("sub_cin",   16'h0010, 16'h0003, 1'b1, 1'b1, 16'h000C, 1'b1, 1'b0);
    repeat (20) @(posedge clk);

    // Streaming: 8 back-to-back beats, out_ready held high.
    #1;
    first = 0; cnt = 0; last = 0;
    for (int n = 0; n < 30; n++) begin
      if (n < 8) drive_random();
      else in_valid = 1'b0;
      @(posedge clk); #1;
      if (out_valid_w[0]) begin
        if (first == 0) first = n + 1;
        cnt++;
        last = n + 1;
      end
    end
    check_eq("stream_first", 32'(first), 32'd4);
    check_eq("stream_count", 32'(cnt), 32'd8);
    check_eq("stream_contig", 32'(last - first), 32'd7);
    repeat (20) @(posedge clk);

    // Backpressure: out_ready low for cycles 6..8 of a 10-beat stream.
    #1;
    sent = 0;
    hold_val = '0;
    drive_random();
    for (int cyc = 0; cyc < 60; cyc++) begin
      stall = (cyc >= 6) && (cyc < 9);
      out_ready = !stall;
      in_valid = (sent < 10);
      #3;
      if (stall) begin
        check_eq("bp_in_ready", 32'(in_ready_w[0]), 32'd0);
        check_eq("bp_out_valid", 32'(out_valid_w[0]), 32'd1);
        if (cyc == 6) hold_val = {out_ovf_w[0], out_cout_w[0], out_sum_w[0]};
        else check_eq("bp_hold", 32'({out_ovf_w[0], out_cout_w[0], out_sum_w[0]}), 32'(hold_val));
      end
      acc = in_valid && in_ready_w[0];
      @(posedge clk); #1;
      if (acc) begin
        sent++;
        if (sent < 10) drive_random();
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check_eq("bp_beats_sent", 32'(sent), 32'd10);
    repeat (25) @(posedge clk);

    // Reset with three beats in flight; in_valid stays high during reset.
    #1;
    for (int n = 0; n < 3; n++) begin
      drive_random();
      @(posedge clk); #1;
    end
    rst = 1'b1;
    drive_random();
    @(posedge clk); #1;
    rst = 1'b0;
    in_valid = 1'b0;
    #1 check_reset_state("midrst");
    repeat (25) @(posedge clk);

    check_eq("drain_s4", 32'(sb0.size()), 32'd0);
    check_eq("drain_s1", 32'(sb1.size()), 32'd0);
    check_eq("drain_s16", 32'(sb2.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
